// File: rtl/lstm_pkg.sv
// Shared types and fixed-point helpers for the LSTM cell-update datapath.
// Macro LSTM_SATURATE_EN: defined -> sat() clamps; undefined -> sat() wraps (two's complement).
package lstm_pkg;

  localparam int unsigned DWIDTH_DEFAULT = 16;
  localparam int unsigned FRAC_DEFAULT   = 8;
  localparam int unsigned WIDE           = 2 * DWIDTH_DEFAULT;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StMul,
    StSum,
    StTanh,
    StHmul,
    StOut
  } state_e;

  function automatic logic [DWIDTH_DEFAULT-1:0] sat(input logic signed [WIDE-1:0] v);
`ifdef LSTM_SATURATE_EN
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    hi = {{(WIDE - DWIDTH_DEFAULT + 1){1'b0}}, {(DWIDTH_DEFAULT - 1){1'b1}}};
    lo = ~hi;
    if (v > hi) return hi[DWIDTH_DEFAULT-1:0];
    if (v < lo) return lo[DWIDTH_DEFAULT-1:0];
`endif
    return v[DWIDTH_DEFAULT-1:0];
  endfunction

  // Full-precision product, floor shift back to the Q format, then sat.
  function automatic logic [DWIDTH_DEFAULT-1:0] fmul(input logic signed [DWIDTH_DEFAULT-1:0] x,
                                                     input logic signed [DWIDTH_DEFAULT-1:0] y);
    logic signed [WIDE-1:0] p;
    p = WIDE'(x) * WIDE'(y);
    return sat(p >>> FRAC_DEFAULT);
  endfunction

  function automatic logic [DWIDTH_DEFAULT-1:0] add_sat(
      input logic signed [DWIDTH_DEFAULT-1:0] x,
      input logic signed [DWIDTH_DEFAULT-1:0] y);
    logic signed [DWIDTH_DEFAULT:0] s;
    s = {x[DWIDTH_DEFAULT-1], x} + {y[DWIDTH_DEFAULT-1], y};
    return sat({{(WIDE - DWIDTH_DEFAULT - 1){s[DWIDTH_DEFAULT]}}, s});
  endfunction

endpackage

// File: rtl/cell_mem.sv
// Cell-state register array: synchronous write, combinational read.
// Addresses at or beyond UNITS read as zero and ignore writes.
module cell_mem #(
  parameter int unsigned UNITS  = 64,
  parameter int unsigned UWIDTH = $clog2(UNITS),
  parameter int unsigned DWIDTH = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [UWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  localparam logic [UWIDTH:0] UNITS_W = (UWIDTH + 1)'(UNITS);

  logic [DWIDTH-1:0] mem [UNITS];
  logic              in_range;

  assign in_range = {1'b0, addr} < UNITS_W;

  always_ff @(posedge clk) begin
    if (we && in_range) mem[addr] <= wdata;
  end

  assign rdata = in_range ? mem[addr] : '0;

endmodule

// File: rtl/cell_update.sv
// LSTM cell update: c_new = i*a + f*c_prev, h = o*tanh(c_new), one unit in flight.
// Saturating arithmetic is selected with LSTM_SATURATE_EN (see lstm_pkg).
module cell_update
  import lstm_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEFAULT,
  parameter int unsigned FRAC   = FRAC_DEFAULT,
  parameter int unsigned UNITS  = 64,
  parameter int unsigned UWIDTH = $clog2(UNITS)
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [UWIDTH-1:0] in_unit,
  input  logic [DWIDTH-1:0] gate_a,
  input  logic [DWIDTH-1:0] gate_i,
  input  logic [DWIDTH-1:0] gate_f,
  input  logic [DWIDTH-1:0] gate_o,
  output logic              tanh_req_valid,
  output logic [DWIDTH-1:0] tanh_arg,
  input  logic              tanh_ret_valid,
  input  logic [DWIDTH-1:0] tanh_ret,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [UWIDTH-1:0] out_unit,
  output logic [DWIDTH-1:0] out_h,
  output logic [DWIDTH-1:0] out_c
);

  state_e state_q, state_d;

  logic [UWIDTH-1:0] clr_idx_q;
  logic [UWIDTH-1:0] unit_q;
  logic [DWIDTH-1:0] a_q, i_q, f_q, o_q, cprev_q;
  logic [DWIDTH-1:0] p1_q, p2_q, c_q, tret_q;
  logic [DWIDTH-1:0] out_h_q, out_c_q;
  logic [UWIDTH-1:0] out_unit_q;

  logic              clr_last;
  logic              accept;
  logic [DWIDTH-1:0] c_sum;

  logic              mem_we;
  logic [UWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  assign clr_last = clr_idx_q == UWIDTH'(UNITS - 1);
  assign accept   = (state_q == StIdle) && !clear && in_valid;
  assign c_sum    = add_sat(p1_q, p2_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: if (clr_last) state_d = StIdle;
      StIdle: begin
        if (clear)         state_d = StClear;
        else if (in_valid) state_d = StMul;
      end
      StMul:   state_d = StSum;
      StSum:   state_d = StTanh;
      StTanh:  if (tanh_ret_valid) state_d = StHmul;
      StHmul:  state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default: state_d = StClear;
    endcase
  end

  // One address port shared by the clear sweep, the c_new write and the c_prev read.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = in_unit;
    mem_wdata = c_sum;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_addr  = clr_idx_q;
      mem_wdata = '0;
    end else if (state_q == StSum) begin
      mem_we   = 1'b1;
      mem_addr = unit_q;
    end
  end

  cell_mem #(
    .UNITS  (UNITS),
    .UWIDTH (UWIDTH),
    .DWIDTH (DWIDTH)
  ) u_cell_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_q <= StClear;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      clr_idx_q  <= '0;
      unit_q     <= '0;
      a_q        <= '0;
      i_q        <= '0;
      f_q        <= '0;
      o_q        <= '0;
      cprev_q    <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      c_q        <= '0;
      tret_q     <= '0;
      out_h_q    <= '0;
      out_c_q    <= '0;
      out_unit_q <= '0;
    end else begin
      clr_idx_q <= ((state_q == StClear) && !clr_last) ? clr_idx_q + 1'b1 : '0;
      if (accept) begin
        unit_q  <= in_unit;
        a_q     <= gate_a;
        i_q     <= gate_i;
        f_q     <= gate_f;
        o_q     <= gate_o;
        cprev_q <= mem_rdata;
      end
      if (state_q == StMul) begin
        p1_q <= fmul(i_q, a_q);
        p2_q <= fmul(f_q, cprev_q);
      end
      if (state_q == StSum) c_q <= c_sum;
      if ((state_q == StTanh) && tanh_ret_valid) tret_q <= tanh_ret;
      // Result registers load once per bundle so they stay put after out_valid drops.
      if (state_q == StHmul) begin
        out_h_q    <= fmul(o_q, tret_q);
        out_c_q    <= c_q;
        out_unit_q <= unit_q;
      end
    end
  end

  assign in_ready       = (state_q == StIdle) && !clear;
  assign tanh_req_valid = state_q == StTanh;
  assign tanh_arg       = c_q;
  assign out_valid      = state_q == StOut;
  assign out_h          = out_h_q;
  assign out_c          = out_c_q;
  assign out_unit       = out_unit_q;

endmodule

// File: tb/tb_cell_update.sv
// Self-checking bench for cell_update: directed scenarios plus randomized bundles
// compared against an integer-arithmetic model of the cell-state rules.
module tb_cell_update;

  localparam int DW    = 16;
  localparam int FR    = 8;
  localparam int UNITS = 64;
  localparam int UW    = 6;

  logic          clk = 1'b0;
  logic          xrst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [UW-1:0] in_unit = '0;
  logic [DW-1:0] gate_a = '0, gate_i = '0, gate_f = '0, gate_o = '0;
  logic          tanh_req_valid;
  logic [DW-1:0] tanh_arg;
  logic          tanh_ret_valid = 1'b0;
  logic [DW-1:0] tanh_ret = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [UW-1:0] out_unit;
  logic [DW-1:0] out_h, out_c;

  int checks = 0;
  int failures = 0;
  int mem_m [UNITS];

  always #5 clk = ~clk;

  cell_update dut (
    .clk            (clk),
    .xrst           (xrst),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_unit        (in_unit),
    .gate_a         (gate_a),
    .gate_i         (gate_i),
    .gate_f         (gate_f),
    .gate_o         (gate_o),
    .tanh_req_valid (tanh_req_valid),
    .tanh_arg       (tanh_arg),
    .tanh_ret_valid (tanh_ret_valid),
    .tanh_ret       (tanh_ret),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_unit       (out_unit),
    .out_h          (out_h),
    .out_c          (out_c)
  );

  function automatic int sat_m(input longint v);
    longint m;
`ifdef LSTM_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
`else
    m = v % 65536;
    if (m < 0) m = m + 65536;
    if (m >= 32768) m = m - 65536;
    return int'(m);
`endif
  endfunction

  function automatic int fmul_m(input int x, input int y);
    longint p, q;
    p = longint'(x) * longint'(y);
    q = p / (2 ** FR);
    if ((p % (2 ** FR) != 0) && (p < 0)) q = q - 1;
    return sat_m(q);
  endfunction

  function automatic int rnd_val();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return $urandom_range(0, 1024) - 512;
    if (sel == 1) return $urandom_range(0, 512);
    if (sel == 2) return ($urandom_range(0, 1) != 0) ? 32767 : -32768;
    return $urandom_range(0, 65535) - 32768;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int u = 0; u < UNITS; u++) mem_m[u] = 0;
  endtask

  task automatic run_op(input string tag, input int unit, input int a, input int gi,
                        input int gf, input int go, input int tv, input int lat,
                        input int hold);
    int k, c_new, h;
    logic [DW-1:0] ce, he;
    c_new = sat_m(longint'(fmul_m(gi, a)) + longint'(fmul_m(gf, mem_m[unit])));
    h     = fmul_m(go, tv);
    ce    = DW'(c_new);
    he    = DW'(h);
    in_unit  = UW'(unit);
    gate_a   = DW'(a);
    gate_i   = DW'(gi);
    gate_f   = DW'(gf);
    gate_o   = DW'(go);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin step(); k++; end
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    gate_a = DW'($urandom);
    tanh_ret_valid = 1'b1;  // junk pulse during MUL must be ignored
    tanh_ret = DW'($urandom);
    step();
    tanh_ret_valid = 1'b0;
    chk({tag, ".req_early"}, 32'(tanh_req_valid), 32'd0);
    step();
    k = 3;
    chk({tag, ".req_lat"}, 32'(tanh_req_valid), 32'd1);
    while (!tanh_req_valid && k < 50) begin step(); k++; end
    chk({tag, ".tanh_arg"}, 32'(tanh_arg), 32'(ce));
    for (int j = 0; j < lat; j++) begin
      step();
      k++;
      chk({tag, ".req_held"}, 32'(tanh_req_valid), 32'd1);
    end
    tanh_ret_valid = 1'b1;
    tanh_ret = DW'(tv);
    step();
    k++;
    tanh_ret_valid = 1'b0;
    tanh_ret = DW'($urandom);
    while (!out_valid && k < 200) begin step(); k++; end
    chk({tag, ".out_lat"}, 32'(k), 32'(5 + lat));
    chk({tag, ".out_c"}, 32'(out_c), 32'(ce));
    chk({tag, ".out_h"}, 32'(out_h), 32'(he));
    chk({tag, ".out_unit"}, 32'(out_unit), 32'(unit));
    for (int j = 0; j < hold; j++) begin
      step();
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_c"}, 32'(out_c), 32'(ce));
      chk({tag, ".hold_h"}, 32'(out_h), 32'(he));
      chk({tag, ".hold_unit"}, 32'(out_unit), 32'(unit));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".out_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".c_kept"}, 32'(out_c), 32'(ce));
    mem_m[unit] = c_new;
  endtask

  initial begin
    clear_model();
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.req_valid", 32'(tanh_req_valid), 32'd0);
    chk("rst.tanh_arg", 32'(tanh_arg), 32'd0);
    chk("rst.out_h", 32'(out_h), 32'd0);
    chk("rst.out_c", 32'(out_c), 32'd0);
    chk("rst.out_unit", 32'(out_unit), 32'd0);
    step();
    xrst = 1'b0;

    // Clear sweep takes UNITS cycles.
    for (int j = 0; j < UNITS - 1; j++) step();
    chk("sweep.busy", 32'(in_ready), 32'd0);
    step();
    step();
    chk("sweep.done", 32'(in_ready), 32'd1);

    for (int u = 0; u < UNITS; u++) run_op("readback", u, 0, 0, 256, 0, 0, 0, 0);

    run_op("unit3_first", 3, 256, 128, 128, 256, 100, 2, 0);
    run_op("unit3_reuse", 3, 256, 128, 128, 256, 100, 2, 0);
    run_op("sat_edge", 5, 32767, 32767, 0, 256, 0, 1, 0);
    run_op("out_hold", 7, rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val(), 0, 5);

    for (int n = 0; n < 24; n++)
      run_op("random", $urandom_range(0, UNITS - 1), rnd_val(), rnd_val(), rnd_val(),
             rnd_val(), rnd_val(), $urandom_range(0, 3), $urandom_range(0, 2));
    for (int n = 0; n < 6; n++)
      run_op("random_u3", 3, rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val(),
             $urandom_range(0, 2), 0);

    // clear wins over in_valid in IDLE; the bundle must be dropped.
    clear = 1'b1;
    in_valid = 1'b1;
    in_unit = UW'(9);
    #1;
    chk("clear_pri.in_ready", 32'(in_ready), 32'd0);
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    clear_model();
    chk("clear_pri.busy", 32'(in_ready), 32'd0);
    for (int j = 0; j < UNITS; j++) step();
    chk("clear_pri.done", 32'(in_ready), 32'd1);
    chk("clear_pri.no_req", 32'(tanh_req_valid), 32'd0);
    run_op("after_clear_u3", 3, 0, 0, 256, 0, 0, 0, 0);
    run_op("after_clear_u9", 9, 0, 0, 256, 0, 0, 0, 0);

    // Reset while waiting for tanh.
    run_op("pre_rst_u3", 3, 256, 256, 0, 256, 50, 0, 0);
    in_unit = UW'(3);
    gate_a = DW'(256);
    gate_i = DW'(256);
    gate_f = DW'(256);
    gate_o = DW'(256);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("rst_mid.in_tanh", 32'(tanh_req_valid), 32'd1);
    xrst = 1'b1;
    #1;
    chk("rst_mid.req", 32'(tanh_req_valid), 32'd0);
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd0);
    step();
    xrst = 1'b0;
    clear_model();
    for (int j = 0; j < UNITS + 1; j++) step();
    chk("rst_mid.sweep_done", 32'(in_ready), 32'd1);
    run_op("rst_mid_u3", 3, 0, 0, 256, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cell_update.md
Name: cell_update

Overview:
- Downstream consumer of the four gate activations (a from tanh_a; i, f, o from the sigmoids) produced by the core gate stage.
- Holds the per-unit cell state c in internal memory and computes c_new = i*a + f*c_prev.
- Sends c_new to the tanh_cn unit over a request/return handshake, then forms h = o*tanh(c_new).
- Returns h and c_new to the sequencer, one unit at a time.

Parameters:
DWIDTH, 16, data width of all signed fixed-point values
FRAC, 8, fractional bits (Q(DWIDTH-FRAC).FRAC)
UNITS, 64, number of hidden units / cell-state entries
UWIDTH, $clog2(UNITS), unit index width

Ports:
clk  in  1  clock
xrst  in  1  reset, asynchronous, active-high
clear  in  1  request zeroing of all cell states (sequence start)
in_valid  in  1  gate bundle valid
in_ready  out  1  block can accept bundle
in_unit  in  UWIDTH  unit index of bundle
gate_a  in  DWIDTH  candidate activation
gate_i  in  DWIDTH  input gate
gate_f  in  DWIDTH  forget gate
gate_o  in  DWIDTH  output gate
tanh_req_valid  out  1  tanh_arg valid toward tanh_cn
tanh_arg  out  DWIDTH  c_new
tanh_ret_valid  in  1  tanh_cn result valid
tanh_ret  in  DWIDTH  tanh(c_new)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_unit  out  UWIDTH  unit index of result
out_h  out  DWIDTH  hidden output
out_c  out  DWIDTH  new cell state

Behaviour:
- Interface: one clock, clk. Reset xrst is asynchronous and active-high.
- On xrst, all outputs go to 0 and the FSM enters CLEAR.
- FSM states: CLEAR, IDLE, MUL, SUM, TANH, HMUL, OUT.
- CLEAR: writes 0 to entry k, k = 0..UNITS-1, one entry per cycle, over UNITS cycles, then goes to IDLE. in_ready = 0.
- IDLE: in_ready = !clear.
  - clear=1 goes to CLEAR. clear has priority over in_valid in the same cycle.
  - in_valid && in_ready latches unit, a, i, f, o, reads c_prev, and goes to MUL.
- clear outside IDLE is ignored. The sequencer holds clear until in_ready is observed.
- MUL: registers p1 = fmul(i,a) and p2 = fmul(f,c_prev).
- SUM: c_new = sat(p1+p2), computed at DWIDTH+1 bits. c_new is written to memory[unit] in this cycle.
- TANH:
  - tanh_req_valid = 1 and tanh_arg = c_new, held until tanh_ret_valid.
  - tanh_ret_valid is sampled only in TANH, including the first TANH cycle (zero-latency tanh is legal). It is ignored in all other states.
- HMUL: h = fmul(o, tanh_ret), registered.
- OUT:
  - out_valid = 1; out_h, out_c, out_unit are stable while out_valid && !out_ready.
  - On out_ready the FSM returns to IDLE.
  - out_valid drops the next cycle. Outputs keep their last value.
- Latency: accept at cycle T; tanh_req_valid at T+3. If tanh returns at T+3+L, out_valid is asserted at T+5+L.
- Throughput: one bundle in flight.
- fmul(x,y): signed 2*DWIDTH product, arithmetic shift right by FRAC (floor), then sat to DWIDTH.
- sat: clamp to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
- in_unit >= UNITS (non-power-of-two UNITS): c_prev reads as 0, no memory write, result still produced.
- The same unit back-to-back always sees the previously written c, because the write precedes the next IDLE.
- xrst mid-operation aborts everything, drops all valids immediately, and restarts CLEAR.

Optional Feature:
- Macro: LSTM_SATURATE_EN.
- Defined: sat() clamps as above.
- Undefined: sat() truncates to the low DWIDTH bits (two's-complement wrap). Saves comparators.

Decomposition:
- Shared package lstm_pkg holds:
  - DWIDTH/FRAC defaults
  - state enum
  - fmul and sat functions, with sat gated by LSTM_SATURATE_EN
- One sub-module: cell_mem, a UNITS x DWIDTH single-port register array with synchronous write and combinational read. It is reused by the block's clear sweep.

Test Plan:
- xrst, then wait UNITS+1 cycles -> in_ready=1. Every unit read back via a=0,i=0,f=256 gives out_c=0.
- unit 3, a=256, i=128, f=128, o=256, tanh returns 100 with L=2 -> out_c=128, out_h=100, out_valid at T+7.
- Same unit 3 again with the same gates -> out_c=192, i.e. c_prev=128 was reused.
- a=i=32767, f=0, LSTM_SATURATE_EN defined -> out_c=32767. Undefined -> out_c=-256 (0xFF00).
- Hold out_ready=0 for 5 cycles in OUT -> out_* stable, in_ready=0. Assert clear together with in_valid in IDLE -> CLEAR taken, bundle not accepted.
- xrst asserted while in TANH -> all valids 0 at once. After the sweep, unit 3 reads c_prev=0.
